axi_lite_mem_subordinate: RTL

//  AXI4-Lite responder fronting a word-addressed on-chip RAM; the far end of axi_manager on the core bus.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_sub_ram.sv | 33 +++
 rtl/axi_lite_mem_subordinate.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite memory subordinate.
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  function automatic resp_t hit_resp(input logic hit);
    return hit ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_sub_ram.sv
// Simple dual-port word RAM: one byte-enabled write port, one registered read port.
// A read and write of the same word on one edge returns the previous contents.
module axi_lite_sub_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  localparam int IDX_W     = $clog2(MEM_DEPTH),
  localparam int NB        = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [NB-1:0]         wbe,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_lite_mem_subordinate.sv
// AXI4-Lite subordinate in front of a word-addressed RAM; independent write and read FSMs.
// Optional byte strobes are enabled with the AXI_SUB_WSTRB_EN macro.
module axi_lite_mem_subordinate
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
`ifdef AXI_SUB_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
`endif
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rvalid,
  input  logic                    axi_rready
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_DEPTH);

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> 2) < ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  logic [0:0]            wr_state;
  logic [0:0]            rd_state;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NB-1:0]         w_strb_q;
  logic [NB-1:0]         strb_in;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_strb;
  logic                  wr_hit;
  logic                  rd_hit;
  logic                  rd_hit_q;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  resp_t                 bresp_q;
  resp_t                 rresp_q;
  logic                  bvalid_q;
  logic                  rvalid_q;

`ifdef AXI_SUB_WSTRB_EN
  assign strb_in = axi_wstrb;
`else
  assign strb_in = '1;
`endif

  assign axi_awready = (wr_state == WR_IDLE) && !aw_held && !reset;
  assign axi_wready  = (wr_state == WR_IDLE) && !w_held  && !reset;
  assign axi_arready = (rd_state == RD_IDLE) && !reset;

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid  && axi_wready;
  assign ar_hs = axi_arvalid && axi_arready;

  // Use the held copy when one half arrived earlier, otherwise the live bus value.
  assign wr_addr   = aw_held ? aw_addr_q : axi_awaddr;
  assign wr_data   = w_held  ? w_data_q  : axi_wdata;
  assign wr_strb   = w_held  ? w_strb_q  : strb_in;
  assign wr_commit = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_hit    = addr_hit(wr_addr);
  assign ram_we    = wr_commit && wr_hit;
  assign rd_hit    = addr_hit(axi_araddr);

  axi_lite_sub_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (addr_index(wr_addr)),
    .wbe   (wr_strb),
    .wdata (wr_data),
    .re    (ar_hs),
    .raddr (addr_index(axi_araddr)),
    .rdata (ram_rdata)
  );

  // Write-channel capture registers
  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= axi_awaddr;
    if (w_hs) begin
      w_data_q <= axi_wdata;
      w_strb_q <= strb_in;
    end
  end

  // Write FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (wr_state == WR_IDLE) begin
      if (wr_commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bresp_q  <= hit_resp(wr_hit);
        bvalid_q <= 1'b1;
        wr_state <= WR_RESP;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
    end else begin
      if (axi_bready) begin
        bvalid_q <= 1'b0;
        wr_state <= WR_IDLE;
      end
    end
  end

  // Read FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rd_hit_q <= 1'b0;
    end else if (rd_state == RD_IDLE) begin
      if (ar_hs) begin
        rresp_q  <= hit_resp(rd_hit);
        rd_hit_q <= rd_hit;
        rvalid_q <= 1'b1;
        rd_state <= RD_DATA;
      end
    end else begin
      if (axi_rready) begin
        rvalid_q <= 1'b0;
        rd_state <= RD_IDLE;
      end
    end
  end

  assign axi_bvalid = bvalid_q;
  assign axi_bresp  = bresp_q;
  assign axi_rvalid = rvalid_q;
  assign axi_rresp  = rresp_q;
  // RAM output only moves on an AR handshake, so gating by the hit flag keeps rdata stable.
  assign axi_rdata  = rd_hit_q ? ram_rdata : '0;

endmodule
